// File: rtl/intra_pkg.sv
// Shared definitions for the intra TU scheduler: size codes, beat budgets and FSM states.
package intra_pkg;

    localparam logic [2:0] TU4  = 3'd2;
    localparam logic [2:0] TU8  = 3'd3;
    localparam logic [2:0] TU16 = 3'd4;
    localparam logic [2:0] TU32 = 3'd5;

    localparam logic [6:0] BEATS_4  = 7'd2;
    localparam logic [6:0] BEATS_8  = 7'd4;
    localparam logic [6:0] BEATS_16 = 7'd16;
    localparam logic [6:0] BEATS_32 = 7'd64;
    localparam logic [6:0] PREP_16  = 7'd1;
    localparam logic [6:0] PREP_32  = 7'd4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } sched_state_e;

    function automatic logic tu_size_legal(input logic [2:0] sz);
        return (sz >= TU4) && (sz <= TU32);
    endfunction

    // Intra jobs need extra reference-preparation beats on the two large sizes.
    function automatic logic [6:0] beat_budget(input logic [2:0] sz, input logic is_inter);
        logic [6:0] b;
        case (sz)
            TU4:     b = BEATS_4;
            TU8:     b = BEATS_8;
            TU16:    b = BEATS_16 + (is_inter ? 7'd0 : PREP_16);
            TU32:    b = BEATS_32 + (is_inter ? 7'd0 : PREP_32);
            default: b = BEATS_4;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/intra_rr_arb2.sv
// Two-way round-robin arbiter (luma/chroma); the pointer moves past whichever side was granted.
module intra_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_y_i,
    input  logic req_c_i,
    output logic gnt_y_o,
    output logic gnt_c_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_y_o = en_i && req_y_i && (!req_c_i || !ptr_q);
        gnt_c_o = en_i && req_c_i && (!req_y_i || ptr_q);
        ptr_d   = ptr_q;
        if (gnt_y_o) begin
            ptr_d = 1'b1;
        end else if (gnt_c_o) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/intra_tu_sched.sv
// Intra TU job scheduler: arbitrates luma/chroma jobs onto the shared prediction engine,
// then sequences engine restart, beat counting, pipeline drain and completion reporting.
module intra_tu_sched
    import intra_pkg::*;
#(
    parameter int unsigned DRAIN_LAT = 3
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       y_valid,
    output logic       y_ready,
    input  logic [2:0] y_tu_size,
    input  logic [5:0] y_mode,
    input  logic       y_is_inter,
    input  logic       c_valid,
    output logic       c_ready,
    input  logic [2:0] c_tu_size,
    input  logic [5:0] c_mode,
    input  logic       c_is_inter,
    input  logic [1:0] c_cidx,
    output logic       eng_rst_n,
    output logic [2:0] eng_tu_size,
    output logic [5:0] eng_mode,
    output logic       eng_is_inter,
    output logic [1:0] eng_cidx,
    output logic       eng_bstop,
    input  logic       ext_stall,
    output logic       busy,
    output logic       tu_done,
    output logic       tu_done_chr,
    output logic       tu_err
);

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_LAT - 1);

    sched_state_e state_q, state_d;
    logic [6:0]   beat_q, beat_d;
    logic [3:0]   drain_q, drain_d;
    logic [2:0]   size_q;
    logic [5:0]   mode_q;
    logic         inter_q;
    logic         chr_q;
    logic [1:0]   cidx_q;
    logic         tu_err_q;
    logic         live_q;

    logic         arb_en;
    logic         gnt_y;
    logic         gnt_c;
    logic         grant;
    logic         sel_legal;
    logic [2:0]   sel_size;
    logic [5:0]   sel_mode;
    logic         sel_inter;
    logic [6:0]   beat_last;

    // live_q keeps every output at zero until the first clock after reset release.
    assign arb_en = live_q && (state_q == IDLE);

    intra_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (arst),
        .en_i    (arb_en),
        .req_y_i (y_valid),
        .req_c_i (c_valid),
        .gnt_y_o (gnt_y),
        .gnt_c_o (gnt_c)
    );

    assign grant     = gnt_y || gnt_c;
    assign sel_size  = gnt_c ? c_tu_size  : y_tu_size;
    assign sel_mode  = gnt_c ? c_mode     : y_mode;
    assign sel_inter = gnt_c ? c_is_inter : y_is_inter;
    assign sel_legal = tu_size_legal(sel_size);
    assign beat_last = beat_budget(size_q, inter_q) - 7'd1;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (grant && sel_legal) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                beat_d  = '0;
                drain_d = '0;
                state_d = RUN;
            end
            RUN: begin
                if (!ext_stall) begin
                    if (beat_q == beat_last) begin
                        state_d = DRAIN;
                    end else begin
                        beat_d = beat_q + 7'd1;
                    end
                end
            end
            DRAIN: begin
                if (!ext_stall) begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = DONE;
                    end else begin
                        drain_d = drain_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            drain_q  <= '0;
            tu_err_q <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            drain_q  <= drain_d;
            tu_err_q <= grant && !sel_legal;
            live_q   <= 1'b1;
        end
    end

    // Illegal-size jobs are handshaken but never reach the engine configuration.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            size_q  <= '0;
            mode_q  <= '0;
            inter_q <= 1'b0;
            chr_q   <= 1'b0;
            cidx_q  <= '0;
        end else if (grant && sel_legal) begin
            size_q  <= sel_size;
            mode_q  <= sel_mode;
            inter_q <= sel_inter;
            chr_q   <= gnt_c;
            cidx_q  <= gnt_c ? c_cidx : 2'd0;
        end
    end

    assign y_ready      = gnt_y;
    assign c_ready      = gnt_c;
    assign eng_rst_n    = live_q && (state_q != LOAD);
    assign eng_bstop    = live_q && ((state_q == RUN) ? ext_stall : 1'b1);
    assign eng_tu_size  = size_q;
    assign eng_mode     = mode_q;
    assign eng_is_inter = inter_q;
    assign eng_cidx     = cidx_q;
    assign busy         = (state_q != IDLE);
    assign tu_done      = (state_q == DONE);
    assign tu_done_chr  = (state_q == DONE) && chr_q;
    assign tu_err       = tu_err_q;

endmodule

// File: tb/tb_intra_tu_sched.sv
// Directed self-checking bench for intra_tu_sched: job latency, stalls, round-robin,
// illegal sizes and asynchronous reset mid-job.
module tb_intra_tu_sched;

    logic       clk = 1'b0;
    logic       arst;
    logic       y_valid, y_ready, y_is_inter;
    logic [2:0] y_tu_size;
    logic [5:0] y_mode;
    logic       c_valid, c_ready, c_is_inter;
    logic [2:0] c_tu_size;
    logic [5:0] c_mode;
    logic [1:0] c_cidx;
    logic       eng_rst_n, eng_is_inter, eng_bstop, ext_stall;
    logic [2:0] eng_tu_size;
    logic [5:0] eng_mode;
    logic [1:0] eng_cidx;
    logic       busy, tu_done, tu_done_chr, tu_err;

    int nCompared   = 0;
    int nMismatched = 0;

    logic       rstnLog  [0:127];
    logic       bstopLog [0:127];
    logic       doneChr;
    logic [2:0] doneSize;
    logic [5:0] doneMode;
    logic       doneInter;
    logic [1:0] doneCidx;

    always #5 clk = ~clk;

    intra_tu_sched #(.DRAIN_LAT(3)) dut (
        .clk          (clk),
        .arst         (arst),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y_tu_size    (y_tu_size),
        .y_mode       (y_mode),
        .y_is_inter   (y_is_inter),
        .c_valid      (c_valid),
        .c_ready      (c_ready),
        .c_tu_size    (c_tu_size),
        .c_mode       (c_mode),
        .c_is_inter   (c_is_inter),
        .c_cidx       (c_cidx),
        .eng_rst_n    (eng_rst_n),
        .eng_tu_size  (eng_tu_size),
        .eng_mode     (eng_mode),
        .eng_is_inter (eng_is_inter),
        .eng_cidx     (eng_cidx),
        .eng_bstop    (eng_bstop),
        .ext_stall    (ext_stall),
        .busy         (busy),
        .tu_done      (tu_done),
        .tu_done_chr  (tu_done_chr),
        .tu_err       (tu_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Raises the requested valids after a clock edge and waits for a grant; side: 0 luma, 1 chroma, 2 both, -1 none.
    task automatic applyStimulus(input bit reqY, input bit reqC, input int limit, output int side);
        side = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            y_valid = reqY;
            c_valid = reqC;
            @(negedge clk);
            if (y_ready || c_ready) begin
                side = (y_ready && c_ready) ? 2 : (c_ready ? 1 : 0);
                break;
            end
        end
    endtask

    // Steps cycles after a grant until tu_done; k counts cycles from the grant cycle.
    task automatic waitDone(input int limit, input int stallFrom, input int stallTo,
                            input bit dropY, input bit dropC, output int doneK, output int beats);
        doneK = -1;
        beats = 0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                if (dropY) y_valid = 1'b0;
                if (dropC) c_valid = 1'b0;
            end
            ext_stall = (k >= stallFrom) && (k < stallTo);
            @(negedge clk);
            rstnLog[k]  = eng_rst_n;
            bstopLog[k] = eng_bstop;
            if (busy && !eng_bstop) beats++;
            if (tu_done) begin
                doneK     = k;
                doneChr   = tu_done_chr;
                doneSize  = eng_tu_size;
                doneMode  = eng_mode;
                doneInter = eng_is_inter;
                doneCidx  = eng_cidx;
                break;
            end
        end
        ext_stall = 1'b0;
    endtask

    task automatic checkIdleAfterDone(input string tag);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({tag, " done pulse"}, tu_done, 0);
        checkOutput({tag, " busy after"}, busy, 0);
    endtask

    initial begin
        int side, doneK, beats, doneCount, errCount;

        arst = 1'b1;
        y_valid = 0; y_tu_size = 0; y_mode = 0; y_is_inter = 0;
        c_valid = 0; c_tu_size = 0; c_mode = 0; c_is_inter = 0; c_cidx = 0;
        ext_stall = 0;

        // Reset state
        @(negedge clk);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst eng_rst_n", eng_rst_n, 0);
        checkOutput("rst eng_bstop", eng_bstop, 0);
        checkOutput("rst tu_done", tu_done, 0);
        checkOutput("rst tu_err", tu_err, 0);
        checkOutput("rst eng_tu_size", eng_tu_size, 0);
        checkOutput("rst eng_cidx", eng_cidx, 0);
        @(posedge clk); #1;
        arst = 1'b0;
        @(posedge clk); #1;

        // 1: luma 8x8 intra, no stall
        y_tu_size = 3'd3; y_mode = 6'd26; y_is_inter = 1'b0;
        applyStimulus(1, 0, 10, side);
        checkOutput("t1 grant side", side, 0);
        waitDone(40, 0, 0, 1, 0, doneK, beats);
        checkOutput("t1 done cycle", doneK, 9);
        checkOutput("t1 beats", beats, 4);
        checkOutput("t1 eng_rst_n load", rstnLog[1], 0);
        checkOutput("t1 eng_rst_n run", rstnLog[2], 1);
        checkOutput("t1 bstop run", bstopLog[2], 0);
        checkOutput("t1 done chr", doneChr, 0);
        checkOutput("t1 eng size", doneSize, 3);
        checkOutput("t1 eng mode", doneMode, 26);
        checkOutput("t1 eng cidx", doneCidx, 0);
        checkIdleAfterDone("t1");

        // 2: luma 32x32 intra with a 5-cycle stall in RUN
        y_tu_size = 3'd5; y_mode = 6'd34; y_is_inter = 1'b0;
        applyStimulus(1, 0, 10, side);
        checkOutput("t2 grant side", side, 0);
        waitDone(120, 10, 15, 1, 0, doneK, beats);
        checkOutput("t2 done cycle", doneK, 78);
        checkOutput("t2 beats", beats, 68);
        checkOutput("t2 bstop before stall", bstopLog[9], 0);
        checkOutput("t2 bstop in stall", bstopLog[12], 1);
        checkOutput("t2 bstop after stall", bstopLog[15], 0);
        checkOutput("t2 eng inter", doneInter, 0);
        checkIdleAfterDone("t2");

        // 6: luma 4x4 held stalled in RUN, released at k=40
        y_tu_size = 3'd2; y_mode = 6'd0; y_is_inter = 1'b0;
        applyStimulus(1, 0, 10, side);
        checkOutput("t6 grant side", side, 0);
        waitDone(120, 1, 40, 1, 0, doneK, beats);
        checkOutput("t6 done cycle", doneK, 45);
        checkOutput("t6 beats", beats, 2);
        checkOutput("t6 bstop while stalled", bstopLog[20], 1);
        checkIdleAfterDone("t6");

        // 4: illegal chroma size is handshaken and dropped
        c_tu_size = 3'd6; c_mode = 6'd3; c_is_inter = 1'b0; c_cidx = 2'd1;
        applyStimulus(0, 1, 10, side);
        checkOutput("t4 grant side", side, 1);
        @(posedge clk); #1;
        c_valid = 1'b0;
        @(negedge clk);
        checkOutput("t4 tu_err", tu_err, 1);
        checkOutput("t4 busy", busy, 0);
        checkOutput("t4 eng_rst_n", eng_rst_n, 1);
        checkOutput("t4 eng size kept", eng_tu_size, 2);
        doneCount = 0;
        errCount  = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (tu_done) doneCount++;
            if (tu_err) errCount++;
        end
        checkOutput("t4 no tu_done", doneCount, 0);
        checkOutput("t4 tu_err pulse", errCount, 0);

        // 3: both requesters held; grants alternate luma, chroma
        y_tu_size = 3'd2; y_mode = 6'd10; y_is_inter = 1'b0;
        c_tu_size = 3'd4; c_mode = 6'd26; c_is_inter = 1'b1; c_cidx = 2'd2;
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1, 1, 10, side);
            checkOutput($sformatf("t3 grant %0d side", j), side, j % 2);
            waitDone(60, 0, 0, j == 3, j == 3, doneK, beats);
            if (j % 2 == 0) begin
                checkOutput($sformatf("t3 job %0d done cycle", j), doneK, 7);
                checkOutput($sformatf("t3 job %0d beats", j), beats, 2);
                checkOutput($sformatf("t3 job %0d chr", j), doneChr, 0);
                checkOutput($sformatf("t3 job %0d cidx", j), doneCidx, 0);
            end else begin
                checkOutput($sformatf("t3 job %0d done cycle", j), doneK, 21);
                checkOutput($sformatf("t3 job %0d beats", j), beats, 16);
                checkOutput($sformatf("t3 job %0d chr", j), doneChr, 1);
                checkOutput($sformatf("t3 job %0d cidx", j), doneCidx, 2);
                checkOutput($sformatf("t3 job %0d size", j), doneSize, 4);
            end
        end
        checkIdleAfterDone("t3");

        // 5: async reset during RUN of a luma 16x16, then re-arbitration from luma
        y_tu_size = 3'd4; y_mode = 6'd18; y_is_inter = 1'b0;
        applyStimulus(1, 0, 10, side);
        checkOutput("t5 grant side", side, 0);
        waitDone(6, 0, 0, 1, 1, doneK, beats);
        checkOutput("t5 running", busy, 1);
        @(posedge clk); #1;
        arst = 1'b1;
        y_tu_size = 3'd3; y_mode = 6'd5;
        c_tu_size = 3'd2; c_mode = 6'd1; c_is_inter = 1'b0; c_cidx = 2'd1;
        y_valid = 1'b1;
        c_valid = 1'b1;
        @(negedge clk);
        checkOutput("t5 busy in reset", busy, 0);
        checkOutput("t5 bstop in reset", eng_bstop, 0);
        checkOutput("t5 eng_rst_n in reset", eng_rst_n, 0);
        checkOutput("t5 tu_done in reset", tu_done, 0);
        checkOutput("t5 y_ready in reset", y_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t5 tu_done held reset", tu_done, 0);
        @(posedge clk); #1;
        arst = 1'b0;
        applyStimulus(1, 1, 10, side);
        checkOutput("t5 regrant side", side, 0);
        waitDone(40, 0, 0, 1, 0, doneK, beats);
        checkOutput("t5 luma done cycle", doneK, 9);
        checkOutput("t5 luma chr", doneChr, 0);
        applyStimulus(0, 1, 10, side);
        checkOutput("t5 chroma side", side, 1);
        waitDone(40, 0, 0, 0, 1, doneK, beats);
        checkOutput("t5 chroma done cycle", doneK, 7);
        checkOutput("t5 chroma chr", doneChr, 1);
        checkOutput("t5 chroma cidx", doneCidx, 1);
        checkIdleAfterDone("t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
